// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared ROM word/depth defaults and arbiter port IDs
package rom_arbiter_pkg;
  localparam int ROM_WORDSIZE = 32;
  localparam int ROM_COL_MAX = 64;
  typedef enum logic {ARB_PORT_F = 1'b0, ARB_PORT_D = 1'b1} arb_port_e;
endpackage

// File: rtl/rom_arb_rsp_reg.sv
// rom_arb_rsp_reg: per-port response register; valid pulses on load, data/err hold otherwise; sync active-low reset
module rom_arb_rsp_reg #(
  parameter int WORDSIZE = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                load_err,
  input  logic [WORDSIZE-1:0] load_data,
  output logic                valid,
  output logic                err,
  output logic [WORDSIZE-1:0] data
);
  always_ff @(posedge clk)
    if (!reset) begin
      valid <= 1'b0;
      err <= 1'b0;
      data <= '0;
    end else begin
      valid <= load;
      if (load) begin
        err <= load_err;
        data <= load_data;
      end
    end
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares the ROM read port between fetch (F) and data (D); ports: clk, reset (sync active-low), f_/d_ valid/addr/ready/rsp_*, rom_addr, rom_data; ROM_ARB_RR_EN selects round-robin, else D has fixed priority
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int WORDSIZE = ROM_WORDSIZE,
  parameter int ROM_DEPTH = ROM_COL_MAX,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                f_valid,
  input  logic [ADDR_W-1:0]   f_addr,
  output logic                f_ready,
  output logic                f_rsp_valid,
  output logic [WORDSIZE-1:0] f_rsp_data,
  output logic                f_rsp_err,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  output logic                d_ready,
  output logic                d_rsp_valid,
  output logic [WORDSIZE-1:0] d_rsp_data,
  output logic                d_rsp_err,
  output logic [31:0]         rom_addr,
  input  logic [WORDSIZE-1:0] rom_data
);
  arb_port_e last_grant;
  logic grant_f, grant_d, bad;
  logic [ADDR_W-1:0] addr;
  logic [WORDSIZE-1:0] word;
`ifdef ROM_ARB_RR_EN
  assign grant_d = reset && d_valid && (!f_valid || last_grant == ARB_PORT_F);
`else
  logic unused_last_grant;
  assign grant_d = reset && d_valid;
  assign unused_last_grant = last_grant;
`endif
  assign grant_f = reset && f_valid && !grant_d;
  assign f_ready = grant_f;
  assign d_ready = grant_d;
  assign addr = grant_d ? d_addr : f_addr;
  assign bad = (addr[1:0] != 2'b00) || (addr[ADDR_W-1:2] >= (ADDR_W-2)'(ROM_DEPTH));
  // Errored requests never touch the ROM, so the address bus idles at 0.
  assign rom_addr = ((grant_f || grant_d) && !bad) ? 32'({addr[ADDR_W-1:2], 2'b00}) : '0;
  assign word = bad ? '0 : rom_data;
  always_ff @(posedge clk)
    if (!reset) last_grant <= ARB_PORT_D;
    else if (grant_f || grant_d) last_grant <= grant_d ? ARB_PORT_D : ARB_PORT_F;
  rom_arb_rsp_reg #(.WORDSIZE(WORDSIZE)) u_f_rsp (
    .clk(clk), .reset(reset), .load(grant_f), .load_err(bad), .load_data(word),
    .valid(f_rsp_valid), .err(f_rsp_err), .data(f_rsp_data)
  );
  rom_arb_rsp_reg #(.WORDSIZE(WORDSIZE)) u_d_rsp (
    .clk(clk), .reset(reset), .load(grant_d), .load_err(bad), .load_data(word),
    .valid(d_rsp_valid), .err(d_rsp_err), .data(d_rsp_data)
  );
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed scoreboard bench for rom_arbiter with a behavioural ROM
module tb_rom_arbiter;
  localparam int W = 32;
  localparam int DEP = 16;
  localparam int AW = 32;
  localparam int IB = $clog2(DEP) + 1;
  typedef struct packed {logic err; logic [W-1:0] data;} rsp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic f_valid = 1'b0, d_valid = 1'b0;
  logic [AW-1:0] f_addr = '0, d_addr = '0;
  logic f_ready, d_ready, f_rsp_valid, d_rsp_valid, f_rsp_err, d_rsp_err;
  logic [W-1:0] f_rsp_data, d_rsp_data, rom_data;
  logic [31:0] rom_addr;
  logic [W-1:0] rom [DEP];
  rsp_t fq[$], dq[$];
  rsp_t f_last = '0, d_last = '0;
  logic lg = 1'b1;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr[IB:2]];
  rom_arbiter #(.WORDSIZE(W), .ROM_DEPTH(DEP), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
    .d_valid(d_valid), .d_addr(d_addr), .d_ready(d_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic check_rsp();
    rsp_t r;
    if (fq.size() > 0) begin
      r = fq.pop_front();
      chk("f_rsp_valid", 64'(f_rsp_valid), 64'(1'b1));
      f_last = r;
    end else chk("f_rsp_valid", 64'(f_rsp_valid), 64'(1'b0));
    chk("f_rsp_data", 64'(f_rsp_data), 64'(f_last.data));
    chk("f_rsp_err", 64'(f_rsp_err), 64'(f_last.err));
    if (dq.size() > 0) begin
      r = dq.pop_front();
      chk("d_rsp_valid", 64'(d_rsp_valid), 64'(1'b1));
      d_last = r;
    end else chk("d_rsp_valid", 64'(d_rsp_valid), 64'(1'b0));
    chk("d_rsp_data", 64'(d_rsp_data), 64'(d_last.data));
    chk("d_rsp_err", 64'(d_rsp_err), 64'(d_last.err));
  endtask
  task automatic step(input logic fv, input logic [AW-1:0] fa, input logic dv, input logic [AW-1:0] da);
    logic gd, gf, e;
    logic [AW-1:0] a;
    rsp_t r;
    @(negedge clk);
    f_valid = fv;
    f_addr = fa;
    d_valid = dv;
    d_addr = da;
`ifdef ROM_ARB_RR_EN
    gd = dv && (!fv || lg == 1'b0);
`else
    gd = dv;
`endif
    gf = fv && !gd;
    a = gd ? da : fa;
    e = (a[1:0] != 2'b00) || (a[AW-1:2] >= (AW-2)'(DEP));
    #1;
    chk("f_ready", 64'(f_ready), 64'(gf));
    chk("d_ready", 64'(d_ready), 64'(gd));
    chk("rom_addr", 64'(rom_addr), ((gf || gd) && !e) ? 64'(a) : 64'd0);
    r.err = e;
    r.data = e ? '0 : rom[a[IB:2]];
    if (gf) fq.push_back(r);
    if (gd) dq.push_back(r);
    if (gf || gd) lg = gd;
    @(posedge clk);
    #1 check_rsp();
  endtask
  initial begin
    for (int i = 0; i < DEP; i++) rom[i] = 32'hA000_0000 + i * 32'h0101_0011;
    f_valid = 1'b1;
    d_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f_ready", 64'(f_ready), 64'd0);
    chk("rst_d_ready", 64'(d_ready), 64'd0);
    check_rsp();
    @(negedge clk);
    reset = 1'b1;
    f_valid = 1'b0;
    d_valid = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0, 1'b1, 32'h4);
    step(1'b1, 32'h8, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 32'h6);
    step(1'b1, 32'(DEP * 4), 1'b0, 32'h0);
    step(1'b1, 32'((DEP - 1) * 4), 1'b0, 32'h0);
    step(1'b1, 32'h5, 1'b1, 32'h3C);
    step(1'b1, 32'h14, 1'b0, 32'h0);
    step(1'b1, 32'h18, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 32'(DEP * 4 + 8));
    step(1'b0, 32'h0, 1'b1, 32'h20);
    @(negedge clk);
    f_valid = 1'b1;
    f_addr = 32'hC;
    d_valid = 1'b0;
    #1 chk("pre_rst_f_ready", 64'(f_ready), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_f_ready", 64'(f_ready), 64'd0);
    chk("mid_rst_d_ready", 64'(d_ready), 64'd0);
    f_last = '0;
    d_last = '0;
    lg = 1'b1;
    @(posedge clk);
    #1 check_rsp();
    @(negedge clk);
    reset = 1'b1;
    f_valid = 1'b0;
    step(1'b1, 32'h0, 1'b1, 32'h4);
    step(1'b1, 32'h0, 1'b1, 32'h4);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single combinational read port of the instruction ROM between two requesters: instruction fetch (port F) and data load (port D, used for constant-table loads).
- Arbitrates per cycle, drives the ROM address, checks alignment and bounds, and returns the registered word to the winner one cycle later.
- Sits between the fetch stage / load unit and the ROM. The ROM keeps its own init/zeroing behaviour.

Parameters:
- WORDSIZE, default `WORDSIZE (32): data width of ROM words and responses.
- ROM_DEPTH, default `ROM_COL_MAX: number of ROM words; word index = addr/4.
- ADDR_W, default 32: request address width (byte address).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk.
- f_valid  in  1  fetch request valid.
- f_addr  in  ADDR_W  fetch byte address.
- f_ready  out  1  fetch request granted this cycle.
- f_rsp_valid  out  1  fetch response valid (1-cycle pulse).
- f_rsp_data  out  WORDSIZE  fetch response word.
- f_rsp_err  out  1  fetch response error (misaligned or out of range).
- d_valid  in  1  data request valid.
- d_addr  in  ADDR_W  data byte address.
- d_ready  out  1  data request granted this cycle.
- d_rsp_valid  out  1  data response valid (1-cycle pulse).
- d_rsp_data  out  WORDSIZE  data response word.
- d_rsp_err  out  1  data response error.
- rom_addr  out  32  byte address to ROM read_addr; always a multiple of 4.
- rom_data  in  WORDSIZE  ROM combinational read data.

Behaviour:
- Reset (reset=0 at posedge):
  - All *_rsp_valid, *_rsp_data and *_rsp_err clear to 0.
  - last_grant is set to D.
  - f_ready and d_ready are forced 0 combinationally while reset=0.
- Handshake:
  - A requester asserts valid with a stable addr until ready=1 in the same cycle. That cycle is the transfer.
  - ready is combinational from the valids and last_grant. Dropping valid before ready is permitted; no request is then recorded.
- Grant:
  - At most one of f_ready/d_ready is 1 per cycle.
  - If only one port is valid, that port is granted.
  - If both are valid, the winner is chosen by the ROM_ARB_RR_EN policy.
  - If neither is valid, no grant; rom_addr=0.
- ROM drive: rom_addr = {granted_addr[ADDR_W-1:2], 2'b00}.
- Checks on the granted request:
  - err = (addr[1:0] != 0) OR (addr[ADDR_W-1:2] >= ROM_DEPTH).
  - On err, the ROM is not read: rom_addr=0 and response data is 0.
- Response latency is exactly 1 cycle:
  - On the posedge after a grant, the winner's rsp_valid=1 and rsp_data = err ? 0 : rom_data (sampled at grant), with rsp_err=err.
  - The other port's rsp_valid=0.
  - rsp_valid deasserts the following cycle unless that port is granted again. Back-to-back grants give continuous rsp_valid.
  - rsp_data/rsp_err hold their last value when rsp_valid=0.
- No response backpressure: requesters must accept a response in its valid cycle.
- Throughput: one request per cycle total, across both ports.
- last_grant updates to the granted port on every grant and holds when idle.
- Reset mid-operation: a request granted in the cycle before reset asserts produces no response. Reset wins and rsp_valid=0.

Optional Feature:
- Macro: ROM_ARB_RR_EN.
- Defined: round-robin on contention. The port not in last_grant wins, so under continuous dual requests grants alternate F,D,F,D… and F wins first after reset.
- Undefined: fixed priority, D always wins on contention, so fetch stalls behind loads. last_grant is still maintained but unused for arbitration.

Decomposition:
- Shared package/defs: WORDSIZE, ROM_COL_MAX, a port-ID constant pair (ARB_PORT_F=0, ARB_PORT_D=1), and the error-reason encoding if later extended.
- One natural sub-module: rom_arb_rsp_reg, the per-port response register (valid/data/err with sync active-low reset), instantiated twice.

Test Plan:
- Reset, then f_valid=1 with f_addr=0x8 only → f_ready=1 same cycle, rom_addr=0x8. Next cycle f_rsp_valid=1, f_rsp_data=rom[2], f_rsp_err=0, d_rsp_valid=0.
- Both valid for 4 cycles (F addr 0x0, D addr 0x4), RR_EN defined → grants F,D,F,D; responses alternate with rom[0]/rom[1]. RR_EN undefined → d_ready=1 all 4 cycles and f_ready=0.
- d_addr=0x6 (misaligned) → d_ready=1, rom_addr=0, next cycle d_rsp_valid=1, d_rsp_err=1, d_rsp_data=0.
- f_addr=ROM_DEPTH*4 (out of range) → f_rsp_err=1, data 0. Address (ROM_DEPTH-1)*4 → err=0 and returns the last word.
- Grant F at cycle N, assert reset=0 at cycle N+1 → f_rsp_valid stays 0, no ready during reset. After release, first contended cycle grants F (RR_EN).
- Idle (no valids) for 3 cycles → f_ready=d_ready=0, rom_addr=0, both rsp_valid=0, and rsp_data holds its previous value.
